// File: rtl/ss_seq_engine_if.sv
// Bundle of command, status, stream and mapper-bus signals for the
// save-state sequencing engine. The engine uses the master view; the
// environment (DMA + mapper) uses the slave view.
interface ss_seq_engine_if;
  logic       cmd_start;
  logic       cmd_save;
  logic [7:0] cur_map_idx;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] sv_dat;
  logic       sv_valid;
  logic       sv_ready;
  logic [7:0] rs_dat;
  logic       rs_valid;
  logic       rs_ready;
  logic       ss_act;
  logic [7:0] ss_addr;
  logic       ss_we;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;

  modport master (
    input  cmd_start, cmd_save, cur_map_idx, sv_ready, rs_dat, rs_valid, ss_rdat,
    output busy, done, err, sv_dat, sv_valid, rs_ready, ss_act, ss_addr, ss_we, ss_wdat
  );

  modport slave (
    output cmd_start, cmd_save, cur_map_idx, sv_ready, rs_dat, rs_valid, ss_rdat,
    input  busy, done, err, sv_dat, sv_valid, rs_ready, ss_act, ss_addr, ss_we, ss_wdat
  );
endinterface

// File: rtl/ss_seq_engine.sv
// Save-state sequencing engine. Walks the mapper slot space (tag slot
// first, then the remaining slots in ascending order) and either dumps the
// slots to an outbound byte stream or restores them from an inbound stream
// after verifying the mapper index tag. All outputs are registered.
module ss_seq_engine #(
  parameter int SS_LEN   = 128,
  parameter int IDX_ADDR = 127,
  parameter int RD_WAIT  = 4,
  parameter int WR_HOLD  = 4
) (
  input  logic           clk,
  input  logic           rst,
  ss_seq_engine_if.master bus
);

  localparam logic [6:0]  LAST_IDX = 7'(SS_LEN - 1);
  localparam logic [7:0]  TAG_ADDR = 8'(IDX_ADDR);
  localparam logic [15:0] RD_LAST  = 16'(RD_WAIT - 1);
  localparam logic [15:0] WR_LAST  = 16'(WR_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_SV_PUSH = 3'd2,
    S_RS_POP  = 3'd3,
    S_WR_STB  = 3'd4,
    S_WR_REC  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // Slot visiting order: index 0 is the tag slot, the rest walk the
  // linear address space with the tag address skipped.
  function automatic logic [7:0] slot_addr(input logic [6:0] idx);
    logic [7:0] lin;
    lin = {1'b0, idx} - 8'd1;
    if (idx == 7'd0) begin
      slot_addr = TAG_ADDR;
    end else if (lin >= TAG_ADDR) begin
      slot_addr = lin + 8'd1;
    end else begin
      slot_addr = lin;
    end
  endfunction

  state_t      state_r;
  logic [6:0]  idx_r;
  logic [15:0] cnt_r;
  logic [7:0]  tag_r;

  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic [7:0]  sv_dat_r;
  logic        sv_valid_r;
  logic        rs_ready_r;
  logic        ss_act_r;
  logic [7:0]  ss_addr_r;
  logic        ss_we_r;
  logic [7:0]  ss_wdat_r;

  logic [6:0]  next_idx_s;
  logic [7:0]  next_addr_s;

  assign next_idx_s  = idx_r + 7'd1;
  assign next_addr_s = slot_addr(next_idx_s);

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.sv_dat   = sv_dat_r;
  assign bus.sv_valid = sv_valid_r;
  assign bus.rs_ready = rs_ready_r;
  assign bus.ss_act   = ss_act_r;
  assign bus.ss_addr  = ss_addr_r;
  assign bus.ss_we    = ss_we_r;
  assign bus.ss_wdat  = ss_wdat_r;

  // Sequencer FSM with all bus/stream/status outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      idx_r      <= 7'd0;
      cnt_r      <= 16'd0;
      tag_r      <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      sv_dat_r   <= 8'd0;
      sv_valid_r <= 1'b0;
      rs_ready_r <= 1'b0;
      ss_act_r   <= 1'b0;
      ss_addr_r  <= 8'd0;
      ss_we_r    <= 1'b0;
      ss_wdat_r  <= 8'd0;
    end else begin
      // done is a single-cycle pulse unless re-armed below
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.cmd_start) begin
            busy_r    <= 1'b1;
            ss_act_r  <= 1'b1;
            err_r     <= 1'b0;
            tag_r     <= bus.cur_map_idx;
            idx_r     <= 7'd0;
            ss_addr_r <= TAG_ADDR;
            cnt_r     <= 16'd0;
            if (bus.cmd_save) begin
              state_r <= S_RD_WAIT;
            end else begin
              rs_ready_r <= 1'b1;
              state_r    <= S_RS_POP;
            end
          end
        end
        S_RD_WAIT: begin
          // address held steady for the mapper's read latency
          if (cnt_r == RD_LAST) begin
            sv_dat_r   <= bus.ss_rdat;
            sv_valid_r <= 1'b1;
            state_r    <= S_SV_PUSH;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        S_SV_PUSH: begin
          if (bus.sv_ready) begin
            sv_valid_r <= 1'b0;
            if (idx_r == LAST_IDX) begin
              ss_act_r <= 1'b0;
              done_r   <= 1'b1;
              state_r  <= S_DONE;
            end else begin
              idx_r     <= next_idx_s;
              ss_addr_r <= next_addr_s;
              cnt_r     <= 16'd0;
              state_r   <= S_RD_WAIT;
            end
          end
        end
        S_RS_POP: begin
          if (bus.rs_valid) begin
            if (idx_r == 7'd0) begin
              // first byte is the mapper index tag, never written back
              if (bus.rs_dat == tag_r) begin
                idx_r     <= next_idx_s;
                ss_addr_r <= next_addr_s;
              end else begin
                err_r      <= 1'b1;
                rs_ready_r <= 1'b0;
                ss_act_r   <= 1'b0;
                done_r     <= 1'b1;
                state_r    <= S_DONE;
              end
            end else begin
              ss_wdat_r  <= bus.rs_dat;
              rs_ready_r <= 1'b0;
              ss_we_r    <= 1'b1;
              cnt_r      <= 16'd0;
              state_r    <= S_WR_STB;
            end
          end
        end
        S_WR_STB: begin
          if (cnt_r == WR_LAST) begin
            ss_we_r <= 1'b0;
            state_r <= S_WR_REC;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        S_WR_REC: begin
          // one idle cycle between strobes before the address moves on
          if (idx_r == LAST_IDX) begin
            ss_act_r <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= S_DONE;
          end else begin
            idx_r      <= next_idx_s;
            ss_addr_r  <= next_addr_s;
            rs_ready_r <= 1'b1;
            state_r    <= S_RS_POP;
          end
        end
        S_DONE: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r     <= 1'b0;
          sv_valid_r <= 1'b0;
          rs_ready_r <= 1'b0;
          ss_act_r   <= 1'b0;
          ss_we_r    <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_seq_engine.sv
// Directed bench for ss_seq_engine: a table of save/restore operations with
// hand-computed expectations, plus a reset-during-write sequence.
module tb_ss_seq_engine;
  logic clk = 1'b0;
  logic rst;

  ss_seq_engine_if bus();

  ss_seq_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       save;
    logic       slow;
    logic [7:0] map_idx;
    logic [7:0] first_byte;
    int         poke_at;
    int         exp_cycles;
    logic       exp_err;
    int         exp_we;
    int         exp_rd;
    int         exp_sv;
  } vec_t;

  vec_t tbl [5];

  int total = 0;
  int bad   = 0;

  // environment state
  int         cyc = 0;
  logic       slow_mode = 1'b0;
  int         rs_ptr = 0;
  int         rs_base = 0;
  int         rs_len = 0;
  int         rs_off;
  logic [7:0] rs_mem [0:255];

  // monitor state
  logic [7:0] sv_q [$];
  logic [7:0] we_a_q [$];
  logic [7:0] we_d_q [$];
  int         width_bad = 0;
  int         stab_bad = 0;
  int         done_cnt = 0;
  logic       pv_hold = 1'b0;
  logic [7:0] p_dat = 8'd0;
  logic       p_we = 1'b0;
  int         we_w = 0;
  logic [7:0] we_a = 8'd0;
  logic [7:0] we_d = 8'd0;

  // free-running cycle count and restore-stream consumption pointer
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rs_valid && bus.rs_ready) rs_ptr <= rs_ptr + 1;
  end

  assign bus.sv_ready = slow_mode ? (cyc % 3 == 0) : 1'b1;
  assign rs_off       = rs_ptr - rs_base;
  assign bus.rs_valid = (rs_off < rs_len);
  assign bus.rs_dat   = rs_mem[rs_off[7:0]];
  assign bus.ss_rdat  = bus.ss_addr ^ 8'h5A;

  // observe stream handshakes, write pulses and done pulses mid-cycle
  always @(negedge clk) begin
    if (bus.sv_valid && bus.sv_ready) sv_q.push_back(bus.sv_dat);
    if (pv_hold && (!bus.sv_valid || bus.sv_dat !== p_dat)) stab_bad <= stab_bad + 1;
    pv_hold <= bus.sv_valid && !bus.sv_ready;
    p_dat   <= bus.sv_dat;
    if (bus.ss_we && !p_we) begin
      we_a_q.push_back(bus.ss_addr);
      we_d_q.push_back(bus.ss_wdat);
      we_a <= bus.ss_addr;
      we_d <= bus.ss_wdat;
      we_w <= 1;
    end else if (bus.ss_we) begin
      if (bus.ss_addr !== we_a || bus.ss_wdat !== we_d) stab_bad <= stab_bad + 1;
      we_w <= we_w + 1;
    end else if (p_we && we_w != 4) begin
      width_bad <= width_bad + 1;
    end
    p_we <= bus.ss_we;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_op(input int id, input vec_t v);
    int         sv_b;
    int         we_b;
    int         wb_b;
    int         sb_b;
    int         dn_b;
    int         n;
    int         mism;
    logic       got;
    logic [7:0] ea;
    @(posedge clk);
    #1;
    sv_b = sv_q.size();
    we_b = we_a_q.size();
    wb_b = width_bad;
    sb_b = stab_bad;
    dn_b = done_cnt;
    rs_mem[0] = v.first_byte;
    for (int j = 1; j < 128; j++) rs_mem[j] = 8'(j);
    rs_len          = v.save ? 0 : 128;
    rs_base         = rs_ptr;
    slow_mode       = v.slow;
    bus.cmd_save    = v.save;
    bus.cur_map_idx = v.map_idx;
    bus.cmd_start   = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_start = 1'b0;
    @(negedge clk);
    chk($sformatf("op%0d.busy_acc", id), bus.busy, 1);
    chk($sformatf("op%0d.act_acc", id), bus.ss_act, 1);
    chk($sformatf("op%0d.addr_first", id), bus.ss_addr, 8'h7F);
    chk($sformatf("op%0d.err_clr", id), bus.err, 0);
    got = 1'b0;
    n   = 0;
    while (!got && n < 4000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == v.poke_at) begin
        bus.cmd_save  = 1'b0;
        bus.cmd_start = 1'b1;
      end else begin
        bus.cmd_start = 1'b0;
      end
      @(negedge clk);
      if (bus.done === 1'b1) got = 1'b1;
    end
    chk($sformatf("op%0d.done_seen", id), got, 1);
    if (v.exp_cycles != 0) chk($sformatf("op%0d.latency", id), n, v.exp_cycles);
    chk($sformatf("op%0d.busy_done", id), bus.busy, 1);
    chk($sformatf("op%0d.act_done", id), bus.ss_act, 0);
    chk($sformatf("op%0d.err_done", id), bus.err, v.exp_err);
    @(posedge clk);
    #1;
    bus.cmd_start = 1'b0;
    @(negedge clk);
    chk($sformatf("op%0d.busy_idle", id), bus.busy, 0);
    chk($sformatf("op%0d.done_idle", id), bus.done, 0);
    repeat (3) @(negedge clk);
    chk($sformatf("op%0d.done_pulses", id), done_cnt - dn_b, 1);
    chk($sformatf("op%0d.sv_bytes", id), sv_q.size() - sv_b, v.exp_sv);
    chk($sformatf("op%0d.we_pulses", id), we_a_q.size() - we_b, v.exp_we);
    chk($sformatf("op%0d.rs_consumed", id), rs_off, v.exp_rd);
    chk($sformatf("op%0d.we_width", id), width_bad - wb_b, 0);
    chk($sformatf("op%0d.stability", id), stab_bad - sb_b, 0);
    chk($sformatf("op%0d.err_sticky", id), bus.err, v.exp_err);
    if (v.exp_sv > 0) begin
      mism = 0;
      for (int k = 0; k < v.exp_sv; k++) begin
        ea = (k == 0) ? 8'h7F : 8'(k - 1);
        if (sv_b + k >= sv_q.size()) mism++;
        else if (sv_q[sv_b + k] !== (ea ^ 8'h5A)) mism++;
      end
      chk($sformatf("op%0d.sv_data_mism", id), mism, 0);
    end
    if (v.exp_we > 0) begin
      mism = 0;
      for (int k = 0; k < v.exp_we; k++) begin
        if (we_b + k >= we_a_q.size()) mism++;
        else if (we_a_q[we_b + k] !== 8'(k) || we_d_q[we_b + k] !== 8'(k + 1)
                 || we_a_q[we_b + k] === 8'h7F) mism++;
      end
      chk($sformatf("op%0d.wr_data_mism", id), mism, 0);
    end
  endtask

  initial begin
    logic found;
    int   dn_b;
    rst             = 1'b1;
    bus.cmd_start   = 1'b0;
    bus.cmd_save    = 1'b0;
    bus.cur_map_idx = 8'd0;
    for (int j = 0; j < 256; j++) rs_mem[j] = 8'd0;

    // save, restore: {save, slow, map_idx, first_byte, poke_at, cycles, err, we, rd, sv}
    tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h00, -1, 640, 1'b0, 0,   0,   128};
    tbl[1] = '{1'b1, 1'b1, 8'h00, 8'h00, -1, 0,   1'b0, 0,   0,   128};
    tbl[2] = '{1'b0, 1'b0, 8'h99, 8'h99, -1, 763, 1'b0, 127, 128, 0};
    tbl[3] = '{1'b0, 1'b0, 8'h99, 8'h98, -1, 1,   1'b1, 0,   1,   0};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 100, 640, 1'b0, 0,  0,   128};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.err", bus.err, 0);
    chk("rst.sv_valid", bus.sv_valid, 0);
    chk("rst.sv_dat", bus.sv_dat, 0);
    chk("rst.rs_ready", bus.rs_ready, 0);
    chk("rst.ss_act", bus.ss_act, 0);
    chk("rst.ss_we", bus.ss_we, 0);
    chk("rst.ss_addr", bus.ss_addr, 0);
    chk("rst.ss_wdat", bus.ss_wdat, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_op(i, tbl[i]);

    // reset while slot 10 is being strobed
    @(posedge clk);
    #1;
    rs_mem[0] = 8'h99;
    for (int j = 1; j < 128; j++) rs_mem[j] = 8'(j);
    rs_len          = 128;
    rs_base         = rs_ptr;
    slow_mode       = 1'b0;
    bus.cmd_save    = 1'b0;
    bus.cur_map_idx = 8'h99;
    bus.cmd_start   = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      if (bus.ss_we === 1'b1 && bus.ss_addr === 8'd10) found = 1'b1;
    end
    chk("rstmid.reach_slot10", found, 1);
    dn_b = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid.ss_we", bus.ss_we, 0);
    chk("rstmid.ss_act", bus.ss_act, 0);
    chk("rstmid.busy", bus.busy, 0);
    chk("rstmid.done", bus.done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstmid.no_done", done_cnt - dn_b, 0);
    chk("rstmid.consumed", rs_off, 12);

    run_op(5, tbl[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
